// File: rtl/operand_fetch_scoreboard_if.sv
// Signal bundle between decode, the register file, the write-back snoop and execute.
// The scoreboard uses the slave view; whatever surrounds it uses the master view.
interface operand_fetch_scoreboard_if #(
  parameter int DATA_W = 32
);
  // decode side
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_src1;
  logic [3:0]        in_src2;
  logic              in_use1;
  logic              in_use2;
  logic [3:0]        in_dest;
  logic              in_wr;
  // register-file read ports
  logic [3:0]        rf_src1;
  logic [3:0]        rf_src2;
  logic [DATA_W-1:0] rf_reg1;
  logic [DATA_W-1:0] rf_reg2;
  // write-back snoop
  logic              writeBackEn;
  logic [3:0]        Dest_wb;
  logic [DATA_W-1:0] Result_WB;
  // execute side
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_val1;
  logic [DATA_W-1:0] op_val2;
  logic [3:0]        op_dest;
  logic              op_wr;

  modport slave (
    input  in_valid, in_src1, in_src2, in_use1, in_use2, in_dest, in_wr,
    output in_ready,
    output rf_src1, rf_src2,
    input  rf_reg1, rf_reg2,
    input  writeBackEn, Dest_wb, Result_WB,
    output op_valid, op_val1, op_val2, op_dest, op_wr,
    input  op_ready
  );

  modport master (
    output in_valid, in_src1, in_src2, in_use1, in_use2, in_dest, in_wr,
    input  in_ready,
    input  rf_src1, rf_src2,
    output rf_reg1, rf_reg2,
    output writeBackEn, Dest_wb, Result_WB,
    input  op_valid, op_val1, op_val2, op_dest, op_wr,
    output op_ready
  );
endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Operand fetch with per-register pending-write scoreboard and write-back bypass; 2-cycle accept-to-valid, 1/cycle.
// Backpressure: OUT holds while op_ready=0, HOLD fills behind it, then in_ready drops; nothing dropped or duplicated.
module operand_fetch_scoreboard #(
  parameter int PEND_W = 2,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  operand_fetch_scoreboard_if.slave  bus
);

  typedef struct packed {
    logic [3:0] src1;
    logic [3:0] src2;
    logic       use1;
    logic       use2;
    logic [3:0] dest;
    logic       wr;
  } hold_t;

  typedef struct packed {
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [3:0]        dest;
    logic              wr;
  } out_t;

  // State bits are {hold_valid, op_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_OUT   = 2'b01,
    ST_HOLD  = 2'b10,
    ST_BOTH  = 2'b11
  } slot_st_t;

  localparam logic [PEND_W-1:0] PEND_ZERO = '0;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  slot_st_t          r_state;
  hold_t             r_hold;
  out_t              r_out;
  logic [PEND_W-1:0] r_pend [16];

  logic              w_hold_vld;
  logic              w_op_vld;
  logic              w_wb_hit1;
  logic              w_wb_hit2;
  logic              w_blk1;
  logic              w_blk2;
  logic              w_dec;
  logic              w_ovf;
  logic              w_resolve;
  logic              w_out_free;
  logic              w_move;
  logic              w_in_rdy;
  logic              w_load;
  logic              w_inc;
  logic              w_hold_nxt;
  logic              w_op_nxt;
  slot_st_t          w_st_nxt;
  logic [DATA_W-1:0] w_opnd1;
  logic [DATA_W-1:0] w_opnd2;
  hold_t             w_hold_in;
  out_t              w_out_in;
  logic [15:0]       w_inc_vec;
  logic [15:0]       w_dec_vec;

  assign w_hold_vld = (r_state == ST_HOLD) || (r_state == ST_BOTH);
  assign w_op_vld   = (r_state == ST_OUT)  || (r_state == ST_BOTH);

  assign w_wb_hit1 = bus.writeBackEn && (bus.Dest_wb == r_hold.src1) && (r_hold.src1 != 4'd0);
  assign w_wb_hit2 = bus.writeBackEn && (bus.Dest_wb == r_hold.src2) && (r_hold.src2 != 4'd0);

  // A source is released early when this cycle's write-back retires its last pending writer.
  assign w_blk1 = r_hold.use1 && (r_hold.src1 != 4'd0) && (r_pend[r_hold.src1] != PEND_ZERO)
                  && !(w_wb_hit1 && (r_pend[r_hold.src1] == PEND_ONE));
  assign w_blk2 = r_hold.use2 && (r_hold.src2 != 4'd0) && (r_pend[r_hold.src2] != PEND_ZERO)
                  && !(w_wb_hit2 && (r_pend[r_hold.src2] == PEND_ONE));

  // Write-backs to untracked or idle registers never touch a counter.
  assign w_dec = bus.writeBackEn && (bus.Dest_wb != 4'd0) && (r_pend[bus.Dest_wb] != PEND_ZERO);

  assign w_ovf = r_hold.wr && (r_hold.dest != 4'd0) && (r_pend[r_hold.dest] == PEND_MAX)
                 && !(w_dec && (bus.Dest_wb == r_hold.dest));

  assign w_resolve  = w_hold_vld && !w_blk1 && !w_blk2 && !w_ovf;
  assign w_out_free = !w_op_vld || bus.op_ready;
  assign w_move     = w_resolve && w_out_free;
  assign w_in_rdy   = !w_hold_vld || w_move;
  assign w_load     = bus.in_valid && w_in_rdy;
  assign w_inc      = w_move && r_hold.wr && (r_hold.dest != 4'd0);

  assign w_opnd1 = !r_hold.use1 ? '0 : (w_wb_hit1 ? bus.Result_WB : bus.rf_reg1);
  assign w_opnd2 = !r_hold.use2 ? '0 : (w_wb_hit2 ? bus.Result_WB : bus.rf_reg2);

  assign w_hold_in = '{src1: bus.in_src1, src2: bus.in_src2, use1: bus.in_use1,
                       use2: bus.in_use2, dest: bus.in_dest, wr: bus.in_wr};
  assign w_out_in  = '{val1: w_opnd1, val2: w_opnd2, dest: r_hold.dest, wr: r_hold.wr};

  assign w_hold_nxt = w_load || (w_hold_vld && !w_move);
  assign w_op_nxt   = w_move || (w_op_vld && !bus.op_ready);
  assign w_st_nxt   = slot_st_t'({w_hold_nxt, w_op_nxt});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_hold  <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_st_nxt;
      if (w_load) begin
        r_hold <= w_hold_in;
      end
      if (w_move) begin
        r_out <= w_out_in;
      end
    end
  end

  always_comb begin
    w_inc_vec = '0;
    w_dec_vec = '0;
    if (w_inc) begin
      w_inc_vec[r_hold.dest] = 1'b1;
    end
    if (w_dec) begin
      w_dec_vec[bus.Dest_wb] = 1'b1;
    end
  end

  // Both qualifiers exclude register 0, so its counter never leaves zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        r_pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (w_inc_vec[i] && !w_dec_vec[i]) begin
          r_pend[i] <= r_pend[i] + PEND_ONE;
        end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
          r_pend[i] <= r_pend[i] - PEND_ONE;
        end
      end
    end
  end

  assign bus.in_ready = w_in_rdy;
  assign bus.rf_src1  = w_hold_vld ? r_hold.src1 : 4'd0;
  assign bus.rf_src2  = w_hold_vld ? r_hold.src2 : 4'd0;
  assign bus.op_valid = w_op_vld;
  assign bus.op_val1  = r_out.val1;
  assign bus.op_val2  = r_out.val2;
  assign bus.op_dest  = r_out.dest;
  assign bus.op_wr    = r_out.wr;

endmodule

// File: tb/tb_operand_fetch_scoreboard.sv
// Bench for operand_fetch_scoreboard: directed hazard scenarios plus a random stream checked
// against a program-order model (each read sees the latest earlier write to that register).
module tb_operand_fetch_scoreboard;
  localparam int DATA_W = 32;
  localparam int PEND_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  operand_fetch_scoreboard_if #(.DATA_W(DATA_W)) bus ();
  operand_fetch_scoreboard #(.PEND_W(PEND_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]  src1, src2, dest;
    logic        use1, use2, wr;
    logic [31:0] res, exp1, exp2;
  } ins_t;
  typedef struct {
    logic [3:0]  dst;
    logic [31:0] dat;
  } wb_t;

  ins_t        stim_q[$];
  ins_t        exp_q[$];
  wb_t         wb_q[$];
  ins_t        cur;
  logic [31:0] rf_mem [16];
  logic [31:0] arch [16];
  int          n_chk, n_bad, n_cons;
  int          rdy_mode, wb_mode;
  logic        gap_en;
  logic        spur_vld;
  logic [3:0]  spur_dst;
  logic [31:0] spur_dat;
  logic        s_acc, s_ov, s_ir, s_hold_prev;
  logic [31:0] s_v1, p_v1, p_v2;
  logic [3:0]  p_dest;
  logic        p_wr;

  assign bus.rf_reg1 = rf_mem[bus.rf_src1];
  assign bus.rf_reg2 = rf_mem[bus.rf_src2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(input logic [3:0] s1, input logic [3:0] s2, input logic u1,
                              input logic u2, input logic [3:0] d, input logic w, input logic [31:0] r);
    ins_t e;
    e.src1 = s1; e.src2 = s2; e.use1 = u1; e.use2 = u2;
    e.dest = d;  e.wr = w;    e.res = r;  e.exp1 = '0; e.exp2 = '0;
    return e;
  endfunction

  // One clock: sample at negedge, then update RF/model and drive at posedge+1.
  task automatic step();
    ins_t e;
    wb_t  w;
    @(negedge clk);
    s_acc = bus.in_valid && bus.in_ready;
    s_ov  = bus.op_valid;
    s_ir  = bus.in_ready;
    s_v1  = bus.op_val1;
    if (s_hold_prev) begin
      check("stall_vld",  32'(bus.op_valid), 32'd1);
      check("stall_val1", bus.op_val1, p_v1);
      check("stall_val2", bus.op_val2, p_v2);
      check("stall_dest", 32'(bus.op_dest), 32'(p_dest));
      check("stall_wr",   32'(bus.op_wr), 32'(p_wr));
    end
    s_hold_prev = bus.op_valid && !bus.op_ready;
    p_v1 = bus.op_val1; p_v2 = bus.op_val2; p_dest = bus.op_dest; p_wr = bus.op_wr;
    if (bus.op_valid && bus.op_ready) begin
      check("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("op_val1", bus.op_val1, e.exp1);
        check("op_val2", bus.op_val2, e.exp2);
        check("op_dest", 32'(bus.op_dest), 32'(e.dest));
        check("op_wr",   32'(bus.op_wr), 32'(e.wr));
        if (e.wr && e.dest != 4'd0) begin
          w.dst = e.dest; w.dat = e.res;
          wb_q.push_back(w);
        end
        n_cons++;
      end
    end
    @(posedge clk);
    #1;
    if (bus.writeBackEn && bus.Dest_wb != 4'd0) rf_mem[bus.Dest_wb] = bus.Result_WB;
    if (s_acc) begin
      e = cur;
      e.exp1 = e.use1 ? arch[e.src1] : 32'd0;
      e.exp2 = e.use2 ? arch[e.src2] : 32'd0;
      if (e.wr && e.dest != 4'd0) arch[e.dest] = e.res;
      exp_q.push_back(e);
      bus.in_valid = 1'b0;
    end
    if (!bus.in_valid && stim_q.size() != 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
      cur = stim_q.pop_front();
      bus.in_src1 = cur.src1; bus.in_src2 = cur.src2;
      bus.in_use1 = cur.use1; bus.in_use2 = cur.use2;
      bus.in_dest = cur.dest; bus.in_wr   = cur.wr;
      bus.in_valid = 1'b1;
    end
    case (rdy_mode)
      0:       bus.op_ready = ($urandom_range(0, 9) < 7);
      1:       bus.op_ready = 1'b1;
      default: bus.op_ready = 1'b0;
    endcase
    bus.writeBackEn = 1'b0;
    bus.Dest_wb     = 4'($urandom_range(0, 15));
    bus.Result_WB   = $urandom;
    if (spur_vld) begin
      bus.writeBackEn = 1'b1; bus.Dest_wb = spur_dst; bus.Result_WB = spur_dat;
    end else if (wb_q.size() != 0 &&
                 (wb_mode == 2 || wb_mode == 3 || (wb_mode == 0 && $urandom_range(0, 1) == 1))) begin
      w = wb_q.pop_front();
      bus.writeBackEn = 1'b1; bus.Dest_wb = w.dst; bus.Result_WB = w.dat;
      if (wb_mode == 3) wb_mode = 1;
    end
  endtask

  task automatic wait_cons(input int target, input int max, output int n);
    n = 0;
    while (n_cons < target && n < max) begin
      step();
      n++;
    end
  endtask

  task automatic clear_model();
    stim_q.delete(); exp_q.delete(); wb_q.delete();
    arch = rf_mem;
    s_hold_prev = 1'b0; n_cons = 0;
    bus.in_valid = 1'b0; bus.writeBackEn = 1'b0; bus.op_ready = 1'b0;
    rdy_mode = 1; wb_mode = 1; gap_en = 1'b0; spur_vld = 1'b0;
  endtask

  task automatic hard_reset();
    clear_model();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  int n;
  logic [31:0] x, y;

  initial begin
    n_chk = 0; n_bad = 0; n_cons = 0;
    for (int i = 0; i < 16; i++) rf_mem[i] = (i == 0) ? 32'd0 : $urandom;
    bus.in_src1 = '0; bus.in_src2 = '0; bus.in_use1 = 1'b0; bus.in_use2 = 1'b0;
    bus.in_dest = '0; bus.in_wr = 1'b0; bus.Dest_wb = '0; bus.Result_WB = '0;
    spur_dst = '0; spur_dat = '0;
    hard_reset();

    // reset state
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_op_valid", 32'(bus.op_valid), 32'd0);
    check("rst_op_val1",  bus.op_val1, 32'd0);
    check("rst_op_val2",  bus.op_val2, 32'd0);
    check("rst_op_dest",  32'(bus.op_dest), 32'd0);
    check("rst_op_wr",    32'(bus.op_wr), 32'd0);
    check("rst_rf_src1",  32'(bus.rf_src1), 32'd0);

    // independent stream: latency 2, throughput 1
    stim_q.push_back(mk(4'd2, 4'd3, 1'b1, 1'b1, 4'd1, 1'b1, $urandom));
    stim_q.push_back(mk(4'd5, 4'd6, 1'b1, 1'b1, 4'd4, 1'b1, $urandom));
    stim_q.push_back(mk(4'd8, 4'd9, 1'b1, 1'b1, 4'd7, 1'b1, $urandom));
    step(); step();
    check("lat_accept", 32'(s_acc), 32'd1);
    step(); check("lat_ov_c1", 32'(s_ov), 32'd0);
    step(); check("lat_ov_c2", 32'(s_ov), 32'd1);
    step(); check("lat_ov_c3", 32'(s_ov), 32'd1);
    step(); check("lat_ov_c4", 32'(s_ov), 32'd1);
    step(); check("lat_ov_c5", 32'(s_ov), 32'd0);
    check("lat_count", 32'(n_cons), 32'd3);

    // RAW stall resolved by write-back bypass
    hard_reset();
    stim_q.push_back(mk(4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b1, 32'hDEADBEEF));
    stim_q.push_back(mk(4'd5, 4'd0, 1'b1, 1'b0, 4'd10, 1'b1, $urandom));
    wait_cons(1, 10, n);
    check("raw_writer_lat", 32'(n), 32'd4);
    repeat (4) step();
    check("raw_stalled", 32'(n_cons), 32'd1);
    wb_mode = 3;
    step(); step(); step();
    check("raw_moved", 32'(n_cons), 32'd2);
    check("raw_bypass", s_v1, 32'hDEADBEEF);
    stim_q.push_back(mk(4'd5, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, $urandom));
    wait_cons(3, 10, n);
    check("raw_pend_clear", 32'(n), 32'd4);

    // pending counter saturation
    hard_reset();
    for (int i = 0; i < 4; i++) stim_q.push_back(mk(4'd0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, $urandom));
    stim_q.push_back(mk(4'd2, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, $urandom));
    repeat (10) step();
    check("sat_4th_stalls", 32'(n_cons), 32'd3);
    wb_mode = 3; repeat (6) step();
    check("sat_4th_moves", 32'(n_cons), 32'd4);
    wb_mode = 3; repeat (3) step();
    wb_mode = 3; repeat (3) step();
    check("sat_count_held", 32'(n_cons), 32'd4);
    wb_mode = 3; repeat (4) step();
    check("sat_reader_done", 32'(n_cons), 32'd5);

    // backpressure
    hard_reset();
    rdy_mode = 2;
    stim_q.push_back(mk(4'd1, 4'd2, 1'b1, 1'b1, 4'd8,  1'b1, $urandom));
    stim_q.push_back(mk(4'd3, 4'd4, 1'b1, 1'b1, 4'd9,  1'b1, $urandom));
    stim_q.push_back(mk(4'd5, 4'd6, 1'b1, 1'b0, 4'd10, 1'b1, $urandom));
    stim_q.push_back(mk(4'd7, 4'd1, 1'b0, 1'b1, 4'd11, 1'b0, $urandom));
    repeat (8) step();
    check("bp_in_ready", 32'(s_ir), 32'd0);
    check("bp_op_valid", 32'(s_ov), 32'd1);
    check("bp_none_out", 32'(n_cons), 32'd0);
    rdy_mode = 1;
    wait_cons(4, 20, n);
    check("bp_drained", 32'(n_cons), 32'd4);

    // R0 reads ignore write-backs to R0; spurious write-back does not underflow
    hard_reset();
    spur_vld = 1'b1; spur_dst = 4'd0; spur_dat = 32'hFFFF_FFFF;
    stim_q.push_back(mk(4'd0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b1, $urandom));
    wait_cons(1, 10, n);
    check("r0_no_stall", 32'(n), 32'd4);
    check("r0_value", s_v1, 32'd0);
    x = $urandom; y = $urandom;
    spur_dst = 4'd9; spur_dat = x; arch[9] = x;
    step();
    spur_vld = 1'b0;
    step();
    stim_q.push_back(mk(4'd0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b1, y));
    stim_q.push_back(mk(4'd9, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, $urandom));
    repeat (8) step();
    check("spur_no_underflow", 32'(n_cons), 32'd2);
    wb_mode = 2;
    repeat (6) step();
    check("spur_reader_done", 32'(n_cons), 32'd3);
    check("spur_reader_val", s_v1, y);

    // asynchronous reset during a stall
    hard_reset();
    rdy_mode = 2;
    stim_q.push_back(mk(4'd1, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, $urandom));
    stim_q.push_back(mk(4'd5, 4'd0, 1'b1, 1'b0, 4'd6, 1'b1, $urandom));
    repeat (5) step();
    check("arst_pre_ov", 32'(s_ov), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_op_valid", 32'(bus.op_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_rf_src1",  32'(bus.rf_src1), 32'd0);
    check("arst_op_dest",  32'(bus.op_dest), 32'd0);
    clear_model();
    @(posedge clk);
    #1 rst = 1'b1;
    x = $urandom;
    spur_vld = 1'b1; spur_dst = 4'd5; spur_dat = x; arch[5] = x;
    step();
    spur_vld = 1'b0;
    step();
    stim_q.push_back(mk(4'd5, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, $urandom));
    wait_cons(1, 10, n);
    check("arst_r5_free", 32'(n), 32'd4);

    // random stream
    hard_reset();
    rdy_mode = 0; wb_mode = 0; gap_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      stim_q.push_back(mk(4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), $urandom));
    end
    n = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0 || bus.in_valid) && n < 20000) begin
      step();
      n++;
    end
    check("rand_all_out", 32'(exp_q.size() + stim_q.size()), 32'd0);
    check("rand_count", 32'(n_cons), 32'd400);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
